// File: rtl/pupil_pkg.sv
// Shared definitions for the pupil-tracking pixel pipeline.
// - state_t       : locator FSM states
// - COORD_W_DEF   : default coordinate width
// - COUNT_W_DEF   : default pixel-count width
// - PIX_WHITE/BLACK : binary pixel levels produced by the binarizer
package pupil_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        ACCUM  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int COORD_W_DEF = 12;
    localparam int COUNT_W_DEF = 20;

    localparam logic [9:0] PIX_WHITE = 10'h3FF;
    localparam logic [9:0] PIX_BLACK = 10'h000;

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position counter for the valid-pixel stream.
// Ports:
//   iCLK, iRST   : clock, asynchronous active-low reset
//   i_clear      : restart the raster at (0,0) this edge
//   i_advance    : one valid pixel consumed this edge
//   o_x, o_y     : position of the next valid pixel
//   o_in_frame   : o_y < V_ACTIVE (position still inside the frame)
// Once y reaches V_ACTIVE the counter holds there instead of wrapping.
module pixel_xy_counter
    import pupil_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               i_clear,
    input  logic               i_advance,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_in_frame
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_END  = COORD_W'(V_ACTIVE);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_base_x;
    logic [COORD_W-1:0] w_base_y;
    logic [COORD_W-1:0] w_nxt_x;
    logic [COORD_W-1:0] w_nxt_y;

    // A clear with advance means the pixel at (0,0) is consumed on the same edge.
    always_comb begin
        w_base_x = i_clear ? '0 : r_x;
        w_base_y = i_clear ? '0 : r_y;
        w_nxt_x  = w_base_x;
        w_nxt_y  = w_base_y;
        if (i_advance && (w_base_y < Y_END)) begin
            if (w_base_x == X_LAST) begin
                w_nxt_x = '0;
                w_nxt_y = w_base_y + 1'b1;
            end else begin
                w_nxt_x = w_base_x + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            r_x <= w_nxt_x;
            r_y <= w_nxt_y;
        end
    end

    assign o_x        = r_x;
    assign o_y        = r_y;
    assign o_in_frame = (r_y < Y_END);

endmodule

// File: rtl/binary_blob_locator.sv
// Locates the target-level blob (the pupil) in a binary pixel stream.
// Per frame it accumulates the bounding box and count of matching pixels
// and publishes box, centre, count and a found flag with a one-cycle
// strobe two edges after the last frame-valid sample.
// Ports:
//   iCLK, iRST            : clock, asynchronous active-low reset
//   iFVAL, iDVAL, iDATA   : frame valid, pixel valid, binary pixel
//   oX_MIN..oY_MAX        : bounding box of matches (0 when not found)
//   oX_CEN, oY_CEN        : floor of box midpoint (0 when not found)
//   oCOUNT                : saturating match count
//   oFOUND                : oCOUNT >= MIN_COUNT
//   oRES_VAL              : one-cycle pulse when results are updated
//   oBUSY                 : frame accumulation in progress
module binary_blob_locator
    import pupil_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int COUNT_W    = COUNT_W_DEF,
    parameter int TARGET_SET = 0,
    parameter int MIN_COUNT  = 64
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFVAL,
    input  logic               iDVAL,
    input  logic [9:0]         iDATA,
    output logic [COORD_W-1:0] oX_MIN,
    output logic [COORD_W-1:0] oX_MAX,
    output logic [COORD_W-1:0] oY_MIN,
    output logic [COORD_W-1:0] oY_MAX,
    output logic [COORD_W-1:0] oX_CEN,
    output logic [COORD_W-1:0] oY_CEN,
    output logic [COUNT_W-1:0] oCOUNT,
    output logic               oFOUND,
    output logic               oRES_VAL,
    output logic               oBUSY
);

    localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_COUNT);

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Sum is one bit wider so the midpoint never loses the carry.
    function automatic logic [COORD_W-1:0] mid(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return COORD_W'(s >> 1);
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_entry;
    logic               w_accept;
    logic               w_report;

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_in_frame;
    logic [COORD_W-1:0] w_px;
    logic [COORD_W-1:0] w_py;
    logic               w_take;
    logic               w_match;
    logic               w_hit;

    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
    logic [COUNT_W-1:0] r_cnt;
    logic [COORD_W-1:0] w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
    logic [COUNT_W-1:0] w_cnt_b;
    logic [COORD_W-1:0] w_xmin_n, w_xmax_n, w_ymin_n, w_ymax_n;
    logic [COUNT_W-1:0] w_cnt_n;

    logic               w_found;

    // ---------------- control FSM ----------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_entry marks the edge that opens a frame; the pixel on it (if any) is (0,0).
    always_comb begin
        w_state_nxt = r_state;
        w_entry     = 1'b0;
        w_accept    = 1'b0;
        w_report    = 1'b0;
        case (r_state)
            SYNC: begin
                if (!iFVAL) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (iFVAL) begin
                    w_state_nxt = ACCUM;
                    w_entry     = 1'b1;
                end
            end
            ACCUM: begin
                if (iFVAL) w_accept = iDVAL;
                else       w_state_nxt = REPORT;
            end
            REPORT: begin
                w_report = 1'b1;
                if (iFVAL) begin
                    w_state_nxt = ACCUM;
                    w_entry     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    // ---------------- raster position ----------------
    assign w_take = (w_entry ? iDVAL : w_accept) & (w_entry | w_in_frame);

    pixel_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .COORD_W  (COORD_W)
    ) u_xy (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .i_clear    (w_entry),
        .i_advance  (w_take),
        .o_x        (w_x),
        .o_y        (w_y),
        .o_in_frame (w_in_frame)
    );

    assign w_px = w_entry ? '0 : w_x;
    assign w_py = w_entry ? '0 : w_y;

    // ---------------- accumulation ----------------
    assign w_match = (TARGET_SET == 0) ? (iDATA == PIX_BLACK) : (iDATA != PIX_BLACK);
    assign w_hit   = w_take & w_match;

    // On an entry edge the accumulators start from their empty values.
    always_comb begin
        w_xmin_b = w_entry ? '1 : r_xmin;
        w_xmax_b = w_entry ? '0 : r_xmax;
        w_ymin_b = w_entry ? '1 : r_ymin;
        w_ymax_b = w_entry ? '0 : r_ymax;
        w_cnt_b  = w_entry ? '0 : r_cnt;

        w_xmin_n = (w_hit && (w_px < w_xmin_b)) ? w_px : w_xmin_b;
        w_xmax_n = (w_hit && (w_px > w_xmax_b)) ? w_px : w_xmax_b;
        w_ymin_n = (w_hit && (w_py < w_ymin_b)) ? w_py : w_ymin_b;
        w_ymax_n = (w_hit && (w_py > w_ymax_b)) ? w_py : w_ymax_b;
        w_cnt_n  = w_hit ? sat_inc(w_cnt_b) : w_cnt_b;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else begin
            r_xmin <= w_xmin_n;
            r_xmax <= w_xmax_n;
            r_ymin <= w_ymin_n;
            r_ymax <= w_ymax_n;
            r_cnt  <= w_cnt_n;
        end
    end

    // ---------------- result registers ----------------
    assign w_found = (r_cnt >= MIN_CNT);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oX_MIN   <= '0;
            oX_MAX   <= '0;
            oY_MIN   <= '0;
            oY_MAX   <= '0;
            oX_CEN   <= '0;
            oY_CEN   <= '0;
            oCOUNT   <= '0;
            oFOUND   <= 1'b0;
            oRES_VAL <= 1'b0;
        end else begin
            oRES_VAL <= w_report;
            if (w_report) begin
                oCOUNT <= r_cnt;
                oFOUND <= w_found;
                if (w_found) begin
                    oX_MIN <= r_xmin;
                    oX_MAX <= r_xmax;
                    oY_MIN <= r_ymin;
                    oY_MAX <= r_ymax;
                    oX_CEN <= mid(r_xmin, r_xmax);
                    oY_CEN <= mid(r_ymin, r_ymax);
                end else begin
                    oX_MIN <= '0;
                    oX_MAX <= '0;
                    oY_MIN <= '0;
                    oY_MAX <= '0;
                    oX_CEN <= '0;
                    oY_CEN <= '0;
                end
            end
        end
    end

    assign oBUSY = (r_state == ACCUM);

endmodule

// File: tb/tb_binary_blob_locator.sv
// Self-checking bench for binary_blob_locator (8x4 frame, MIN_COUNT=2).
module tb_binary_blob_locator;
    import pupil_pkg::*;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int CW   = 12;
    localparam int NW   = 20;
    localparam int MINC = 2;

    logic          iCLK  = 1'b0;
    logic          iRST  = 1'b0;
    logic          iFVAL = 1'b0;
    logic          iDVAL = 1'b0;
    logic [9:0]    iDATA = 10'd0;
    logic [CW-1:0] oX_MIN, oX_MAX, oY_MIN, oY_MAX, oX_CEN, oY_CEN;
    logic [NW-1:0] oCOUNT;
    logic          oFOUND, oRES_VAL, oBUSY;

    always #5 iCLK = ~iCLK;

    binary_blob_locator #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .COORD_W    (CW),
        .COUNT_W    (NW),
        .TARGET_SET (0),
        .MIN_COUNT  (MINC)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iFVAL    (iFVAL),
        .iDVAL    (iDVAL),
        .iDATA    (iDATA),
        .oX_MIN   (oX_MIN),
        .oX_MAX   (oX_MAX),
        .oY_MIN   (oY_MIN),
        .oY_MAX   (oY_MAX),
        .oX_CEN   (oX_CEN),
        .oY_CEN   (oY_CEN),
        .oCOUNT   (oCOUNT),
        .oFOUND   (oFOUND),
        .oRES_VAL (oRES_VAL),
        .oBUSY    (oBUSY)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] q[$];
    int         pidx;
    int         e_xmin, e_xmax, e_ymin, e_ymax, e_xcen, e_ycen, e_cnt, e_found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge iCLK);
    endtask

    task automatic fill(input int n, input logic [9:0] v);
        q.delete();
        repeat (n) q.push_back(v);
    endtask

    // Reference: the i-th valid pixel sits at (i % H, i / H); rows >= V are dropped.
    task automatic model();
        int c;
        int xmn, xmx, ymn, ymx;
        c = 0; xmn = 1 << 30; xmx = -1; ymn = 1 << 30; ymx = -1;
        for (int i = 0; i < q.size(); i++) begin
            int x;
            int y;
            x = i % H;
            y = i / H;
            if (y < V && q[i] == PIX_BLACK) begin
                c++;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (y < ymn) ymn = y;
                if (y > ymx) ymx = y;
            end
        end
        e_cnt   = c;
        e_found = (c >= MINC) ? 1 : 0;
        if (e_found != 0) begin
            e_xmin = xmn; e_xmax = xmx; e_ymin = ymn; e_ymax = ymx;
            e_xcen = (xmn + xmx) / 2;
            e_ycen = (ymn + ymx) / 2;
        end else begin
            e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_xcen = 0; e_ycen = 0;
        end
    endtask

    task automatic check_report(input string tag);
        chk({tag, ".resval"}, 32'(oRES_VAL), 1);
        chk({tag, ".xmin"},   32'(oX_MIN),   e_xmin);
        chk({tag, ".xmax"},   32'(oX_MAX),   e_xmax);
        chk({tag, ".ymin"},   32'(oY_MIN),   e_ymin);
        chk({tag, ".ymax"},   32'(oY_MAX),   e_ymax);
        chk({tag, ".xcen"},   32'(oX_CEN),   e_xcen);
        chk({tag, ".ycen"},   32'(oY_CEN),   e_ycen);
        chk({tag, ".count"},  32'(oCOUNT),   e_cnt);
        chk({tag, ".found"},  32'(oFOUND),   e_found);
    endtask

    // Drive the entry slot of a frame (caller then steps the clock).
    task automatic entry_drive(input bit ev);
        iFVAL = 1'b1;
        if (ev) begin
            iDVAL = 1'b1; iDATA = q[0]; pidx = 1;
        end else begin
            iDVAL = 1'b0; iDATA = PIX_BLACK; pidx = 0;
        end
    endtask

    // Remaining pixels, with invalid gap cycles carrying junk data.
    task automatic body_rest(input int gap);
        while (pidx < q.size()) begin
            if (int'($urandom_range(99)) < gap) begin
                iDVAL = 1'b0;
                iDATA = ($urandom_range(1) != 0) ? PIX_BLACK : PIX_WHITE;
            end else begin
                iDVAL = 1'b1;
                iDATA = q[pidx];
                pidx++;
            end
            step();
        end
    endtask

    // Frame-end edge: a black valid pixel here must be ignored.
    task automatic end_drive();
        iFVAL = 1'b0; iDVAL = 1'b1; iDATA = PIX_BLACK;
    endtask

    task automatic run_frame(input int gap, input bit ev, input string tag);
        model();
        entry_drive(ev);
        step();
        chk({tag, ".busy"}, 32'(oBUSY), 1);
        body_rest(gap);
        end_drive();
        step();
        chk({tag, ".lat1"}, 32'(oRES_VAL), 0);
        iFVAL = 1'b0; iDVAL = 1'b0;
        step();
        check_report(tag);
        step();
        chk({tag, ".pulse"}, 32'(oRES_VAL), 0);
        chk({tag, ".hold"},  32'(oCOUNT),   e_cnt);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst.xmin",  32'(oX_MIN),   0);
        chk("rst.xmax",  32'(oX_MAX),   0);
        chk("rst.ymin",  32'(oY_MIN),   0);
        chk("rst.ymax",  32'(oY_MAX),   0);
        chk("rst.xcen",  32'(oX_CEN),   0);
        chk("rst.ycen",  32'(oY_CEN),   0);
        chk("rst.count", 32'(oCOUNT),   0);
        chk("rst.found", 32'(oFOUND),   0);
        chk("rst.resv",  32'(oRES_VAL), 0);
        chk("rst.busy",  32'(oBUSY),    0);
        iRST = 1'b1;
        repeat (2) step();

        // All-white frame
        fill(H * V, PIX_WHITE);
        run_frame(0, 1'b0, "white");

        // Three black pixels
        fill(H * V, PIX_WHITE);
        q[10] = PIX_BLACK; q[13] = PIX_BLACK; q[19] = PIX_BLACK;
        run_frame(0, 1'b0, "three");

        // Same with gaps and a black pixel on the entry edge
        q[0] = PIX_BLACK;
        run_frame(30, 1'b1, "gaps");

        // Reset mid-frame with iFVAL held high
        fill(H * V, PIX_BLACK);
        entry_drive(1'b0);
        step();
        repeat (10) begin
            iDVAL = 1'b1; iDATA = PIX_BLACK; step();
        end
        iRST = 1'b0;
        #1;
        chk("mrst.count", 32'(oCOUNT), 0);
        chk("mrst.found", 32'(oFOUND), 0);
        chk("mrst.xmax",  32'(oX_MAX), 0);
        chk("mrst.busy",  32'(oBUSY),  0);
        step();
        iRST = 1'b1;
        repeat (4) begin
            iDVAL = 1'b1; iDATA = PIX_BLACK;
            step();
            chk("mrst.noresv", 32'(oRES_VAL), 0);
            chk("mrst.sync",   32'(oBUSY),    0);
        end
        iFVAL = 1'b0; iDVAL = 1'b0;
        repeat (3) begin
            step();
            chk("mrst.noresv2", 32'(oRES_VAL), 0);
        end
        fill(H * V, PIX_WHITE);
        q[10] = PIX_BLACK; q[13] = PIX_BLACK; q[19] = PIX_BLACK;
        run_frame(10, 1'b0, "after_rst");

        // Single black pixel at the last position
        fill(H * V, PIX_WHITE);
        q[31] = PIX_BLACK;
        run_frame(0, 1'b0, "single");

        // Overlong frame: extras are ignored, no wrap to y=0
        repeat (8) q.push_back(PIX_BLACK);
        run_frame(20, 1'b0, "overlong");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            int n;
            n = int'($urandom_range(40, 20));
            q.delete();
            for (int i = 0; i < n; i++)
                q.push_back(($urandom_range(3) == 0) ? PIX_BLACK : PIX_WHITE);
            run_frame(int'($urandom_range(40)), bit'($urandom_range(1)), "rand");
        end

        // Back-to-back frames with a single low iFVAL cycle
        fill(H * V, PIX_WHITE);
        q[9] = PIX_BLACK; q[22] = PIX_BLACK; q[30] = PIX_BLACK;
        model();
        entry_drive(1'b0);
        step();
        chk("b2bA.busy", 32'(oBUSY), 1);
        body_rest(15);
        end_drive();
        step();
        chk("b2bA.lat1", 32'(oRES_VAL), 0);
        fill(H * V, PIX_WHITE);
        q[0] = PIX_BLACK; q[27] = PIX_BLACK;
        entry_drive(1'b1);
        step();
        check_report("b2bA");
        chk("b2bB.busy", 32'(oBUSY), 1);
        model();
        body_rest(15);
        end_drive();
        step();
        chk("b2bB.lat1", 32'(oRES_VAL), 0);
        iFVAL = 1'b0; iDVAL = 1'b0;
        step();
        check_report("b2bB");
        step();
        chk("b2bB.pulse", 32'(oRES_VAL), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_blob_locator.md
Name: binary_blob_locator

Overview:
- Consumer of the thresholded pixel stream: takes the 10-bit binary pixel stream (0x000 / 0x3FF) plus frame-valid and locates the target-level blob, i.e. the pupil, which thresholds to 0.
- Accumulates per frame the bounding box, pixel count and box centre of matching pixels. Publishes them with a one-cycle result strobe at frame end.
- Sits downstream of the binarizer, upstream of overlay/reporting logic.

Parameters:
- H_ACTIVE, 640, valid pixels per line.
- V_ACTIVE, 480, lines per frame.
- COORD_W, 12, coordinate width; must satisfy 2^COORD_W > max(H_ACTIVE, V_ACTIVE).
- COUNT_W, 20, pixel-count width; must satisfy 2^COUNT_W > H_ACTIVE*V_ACTIVE.
- TARGET_SET, 0, 0 = match pixels with iDATA==0; 1 = match pixels with iDATA!=0.
- MIN_COUNT, 64, minimum matches for oFOUND=1.

Ports:
- iCLK, in, 1, clock.
- iRST, in, 1, asynchronous active-low reset.
- iFVAL, in, 1, frame valid, high across the whole frame.
- iDVAL, in, 1, pixel valid.
- iDATA, in, 10, binary pixel.
- oX_MIN, out, COORD_W, leftmost matching x.
- oX_MAX, out, COORD_W, rightmost matching x.
- oY_MIN, out, COORD_W, top matching y.
- oY_MAX, out, COORD_W, bottom matching y.
- oX_CEN, out, COORD_W, (oX_MIN+oX_MAX)>>1.
- oY_CEN, out, COORD_W, (oY_MIN+oY_MAX)>>1.
- oCOUNT, out, COUNT_W, matching pixels in the frame, saturating.
- oFOUND, out, 1, oCOUNT >= MIN_COUNT.
- oRES_VAL, out, 1, one-cycle pulse: results updated.
- oBUSY, out, 1, high in ACCUM.

Behaviour:
- Reset (async, iRST low):
  - All outputs 0; state SYNC.
  - Internal x, y, count = 0; min regs = all ones; max regs = 0.
- State SYNC: wait for iFVAL sampled 0, then IDLE. Guarantees a partial frame after reset is never reported.
- State IDLE: on iFVAL sampled 1, go to ACCUM ("entry edge"):
  - counters and accumulators initialise;
  - if iDVAL=1 on the entry edge, that pixel is processed as x=0, y=0.
- State ACCUM, each edge with iFVAL=1 and iDVAL=1:
  - Match when (TARGET_SET=0 and iDATA==0) or (TARGET_SET=1 and iDATA!=0).
  - On a match: update x/y min/max with the current coordinates; count+1, saturating at all ones.
  - x increments per valid pixel. At x==H_ACTIVE-1, x wraps to 0 and y increments.
  - Once y reaches V_ACTIVE, further pixels are ignored (no wrap into y=0) until frame end.
  - iDVAL gaps are allowed anywhere; x/y advance only on valid pixels.
- ACCUM frame end: iFVAL sampled 0 → REPORT. iDVAL on that edge is ignored.
- State REPORT (exactly one cycle): at the next edge all outputs are registered and oRES_VAL=1 for that cycle.
  - Latency: oRES_VAL rises on the 2nd edge after the last iFVAL=1 sample.
  - If count >= MIN_COUNT: oFOUND=1; box, centre and count outputs take the accumulated values.
  - Otherwise: oFOUND=0, box and centre = 0, oCOUNT = actual count.
  - Centre arithmetic uses a COORD_W+1 bit sum, then shifts right by 1 (floor).
  - Exit from REPORT: iFVAL=1 at that edge is a new entry edge → ACCUM; otherwise → IDLE.
- Outputs hold between reports; only a REPORT edge or reset changes them.
- Truncated frame (iFVAL falls early): report normally with the partial accumulation.
- Reset mid-frame: everything clears immediately; no report for that frame. Resume in SYNC.

Decomposition:
- Shared package pupil_pkg:
  - state enum (SYNC, IDLE, ACCUM, REPORT);
  - default COORD_W/COUNT_W constants;
  - pixel level constants PIX_WHITE=10'h3FF, PIX_BLACK=10'h000 (shared with the binarizer).
- One sub-module, pixel_xy_counter:
  - x/y raster counter with clear, advance and overflow-hold;
  - outputs x, y and in_frame (y < V_ACTIVE).

Test Plan (H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=2, TARGET_SET=0):
- All-white frame, 32 pixels of 0x3FF → one oRES_VAL pulse 2 cycles after iFVAL falls; oCOUNT=0, oFOUND=0, box and centre 0.
- Black pixels at (2,1), (5,1), (3,2) → oX_MIN=2, oX_MAX=5, oY_MIN=1, oY_MAX=2, oX_CEN=3, oY_CEN=1, oCOUNT=3, oFOUND=1.
- Same frame with random iDVAL gaps, and iDVAL=1 on the entry edge carrying black → identical results; the entry pixel counts as (0,0) so oX_MIN=0, oY_MIN=0, oCOUNT=4.
- Single black pixel at (7,3) → oCOUNT=1, oFOUND=0, box 0. Then 40 valid pixels (8 extra, all black) → extras ignored; no y wrap.
- Reset asserted mid-frame with iFVAL held high, released mid-frame → no oRES_VAL for that frame; the next full frame reports correctly.
- Back-to-back frames, iFVAL low for exactly one cycle between them → two oRES_VAL pulses with independent results; the second frame's first pixel is accepted on the REPORT→ACCUM edge.
